// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - AHB-Lite encodings and data-phase state type shared by the response mux.
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DP_IDLE,
      DP_SLAVE,
      DP_ERR1,
      DP_ERR2
   } dp_state_t;

   // BUSY carries no data phase, so it is grouped with IDLE as inactive.
   function automatic logic htrans_active(input logic [1:0] htrans);
      logic act;
      act = 1'b0;
      case (htrans)
         HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
         default:                   act = 1'b0;
      endcase
      return act;
   endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - default slave producing the two-cycle ERROR for unmapped active transfers.
module ahb_default_slave
   import ahb_lite_pkg::*;
(
   input  logic hclk,
   input  logic hresetn,
   input  logic unmapped_dp,
   output logic hreadyout,
   output logic hresp
);

   logic second_q;
   logic second_d;

   // unmapped_dp holds through the stalled first cycle, so second_q toggles
   // exactly once per ERROR and clears itself for a back-to-back ERROR.
   always_comb begin
      second_d = unmapped_dp && !second_q;
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         second_q <= 1'b0;
      end else begin
         second_q <= second_d;
      end
   end

   always_comb begin
      hreadyout = !unmapped_dp || second_q;
      hresp     = unmapped_dp ? HRESP_ERROR : HRESP_OKAY;
   end

endmodule

// File: rtl/ahb_slave_resp_mux.sv
// rtl/ahb_slave_resp_mux.sv - AHB-Lite data-phase response mux with built-in default slave.
module ahb_slave_resp_mux
   import ahb_lite_pkg::*;
#(
   parameter int SLAVE_NUM  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic [$clog2(SLAVE_NUM)-1:0] MUX_SEL,
   input  logic                         ADDR_HIT,
   input  logic [1:0]                   HTRANS,
   input  logic [DATA_WIDTH-1:0]        HRDATA_1,
   input  logic [DATA_WIDTH-1:0]        HRDATA_2,
   input  logic [DATA_WIDTH-1:0]        HRDATA_3,
   input  logic [DATA_WIDTH-1:0]        HRDATA_4,
   input  logic                         HREADYOUT_1,
   input  logic                         HREADYOUT_2,
   input  logic                         HREADYOUT_3,
   input  logic                         HREADYOUT_4,
   input  logic                         HRESP_1,
   input  logic                         HRESP_2,
   input  logic                         HRESP_3,
   input  logic                         HRESP_4,
   output logic [DATA_WIDTH-1:0]        HRDATA,
   output logic                         HREADY,
   output logic                         HRESP
);

   localparam int SEL_W = $clog2(SLAVE_NUM);

   dp_state_t        state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             act_q, act_d;
   logic             hit_q, hit_d;

   logic [DATA_WIDTH-1:0] slv_rdata [4];
   logic [3:0]            slv_ready;
   logic [3:0]            slv_resp;

   logic [DATA_WIDTH-1:0] mux_rdata;
   logic                  mux_ready;
   logic                  mux_resp;

   logic ds_hreadyout;
   logic ds_hresp;

   always_comb begin
      slv_rdata[0] = HRDATA_1;
      slv_rdata[1] = HRDATA_2;
      slv_rdata[2] = HRDATA_3;
      slv_rdata[3] = HRDATA_4;
      slv_ready    = {HREADYOUT_4, HREADYOUT_3, HREADYOUT_2, HREADYOUT_1};
      slv_resp     = {HRESP_4, HRESP_3, HRESP_2, HRESP_1};
   end

   // An index with no slave behind it falls through to a zero-wait OKAY.
   always_comb begin
      mux_rdata = '0;
      mux_ready = 1'b1;
      mux_resp  = HRESP_OKAY;
      for (int i = 0; i < 4; i++) begin
         if (i < SLAVE_NUM && sel_q == SEL_W'(i)) begin
            mux_rdata = slv_rdata[i];
            mux_ready = slv_ready[i];
            mux_resp  = slv_resp[i];
         end
      end
   end

   ahb_default_slave u_default_slave (
      .hclk        (HCLK),
      .hresetn     (HRESETn),
      .unmapped_dp (act_q && !hit_q),
      .hreadyout   (ds_hreadyout),
      .hresp       (ds_hresp)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      act_d   = act_q;
      hit_d   = hit_q;
      if (HREADY) begin
         sel_d = MUX_SEL;
         act_d = htrans_active(HTRANS);
         hit_d = ADDR_HIT;
      end
      if (state_q == DP_ERR1) begin
         state_d = DP_ERR2;
      end else if (HREADY) begin
         if (!htrans_active(HTRANS)) begin
            state_d = DP_IDLE;
         end else if (ADDR_HIT) begin
            state_d = DP_SLAVE;
         end else begin
            state_d = DP_ERR1;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= DP_IDLE;
         sel_q   <= '0;
         act_q   <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         act_q   <= act_d;
         hit_q   <= hit_d;
      end
   end

   always_comb begin
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      case (state_q)
         DP_SLAVE: begin
            HRDATA = mux_rdata;
            HREADY = mux_ready;
            HRESP  = mux_resp;
         end
         DP_ERR1, DP_ERR2: begin
            HREADY = ds_hreadyout;
            HRESP  = ds_hresp;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_ahb_slave_resp_mux.sv
// tb/tb_ahb_slave_resp_mux.sv - self-checking bench for ahb_slave_resp_mux against a transfer-level model.
module tb_ahb_slave_resp_mux;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic [1:0]  MUX_SEL = '0;
   logic        ADDR_HIT = 1'b0;
   logic [1:0]  HTRANS = 2'b00;
   logic [31:0] HRDATA_1 = '0, HRDATA_2 = '0, HRDATA_3 = '0, HRDATA_4 = '0;
   logic        HREADYOUT_1 = 1'b1, HREADYOUT_2 = 1'b1, HREADYOUT_3 = 1'b1, HREADYOUT_4 = 1'b1;
   logic        HRESP_1 = 1'b0, HRESP_2 = 1'b0, HRESP_3 = 1'b0, HRESP_4 = 1'b0;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   int errors = 0;
   int checks = 0;

   // Model: what the current data phase belongs to (0 none, 1 slave, 2 error) and how far it has got.
   int          m_kind = 0;
   int          m_sel = 0;
   int          m_err_n = 0;
   logic        exp_ready, exp_resp;
   logic [31:0] exp_rdata;

   ahb_slave_resp_mux #(.SLAVE_NUM(4), .DATA_WIDTH(32)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .MUX_SEL(MUX_SEL), .ADDR_HIT(ADDR_HIT), .HTRANS(HTRANS),
      .HRDATA_1(HRDATA_1), .HRDATA_2(HRDATA_2), .HRDATA_3(HRDATA_3), .HRDATA_4(HRDATA_4),
      .HREADYOUT_1(HREADYOUT_1), .HREADYOUT_2(HREADYOUT_2), .HREADYOUT_3(HREADYOUT_3),
      .HREADYOUT_4(HREADYOUT_4),
      .HRESP_1(HRESP_1), .HRESP_2(HRESP_2), .HRESP_3(HRESP_3), .HRESP_4(HRESP_4),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   function automatic logic [31:0] slv_rd(int i);
      case (i)
         0: return HRDATA_1;
         1: return HRDATA_2;
         2: return HRDATA_3;
         default: return HRDATA_4;
      endcase
   endfunction

   function automatic logic slv_rdy(int i);
      case (i)
         0: return HREADYOUT_1;
         1: return HREADYOUT_2;
         2: return HREADYOUT_3;
         default: return HREADYOUT_4;
      endcase
   endfunction

   function automatic logic slv_rsp(int i);
      case (i)
         0: return HRESP_1;
         1: return HRESP_2;
         2: return HRESP_3;
         default: return HRESP_4;
      endcase
   endfunction

   function automatic void model_eval();
      exp_ready = 1'b1;
      exp_resp  = 1'b0;
      exp_rdata = '0;
      if (HRESETn && m_kind == 1) begin
         exp_ready = slv_rdy(m_sel);
         exp_resp  = slv_rsp(m_sel);
         exp_rdata = slv_rd(m_sel);
      end else if (HRESETn && m_kind == 2) begin
         exp_ready = (m_err_n != 0);
         exp_resp  = 1'b1;
      end
   endfunction

   task automatic tick();
      @(posedge HCLK);
      if (!HRESETn) begin
         m_kind = 0;
      end else begin
         model_eval();
         if (exp_ready) begin
            m_sel   = int'(MUX_SEL);
            m_err_n = 0;
            if (!HTRANS[1]) m_kind = 0;
            else if (ADDR_HIT) m_kind = 1;
            else m_kind = 2;
         end else if (m_kind == 2) begin
            m_err_n++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      #2 HRESETn = 1'b0;
      #1;
      checks++;
      if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_initial: got rdy=%b resp=%b data=%h want 1 0 0", HREADY, HRESP, HRDATA);
      end
      @(posedge HCLK); #1;
      HRESETn = 1'b1; m_kind = 0;
      MUX_SEL = 2'd1; ADDR_HIT = 1'b1; HTRANS = 2'b10; HREADYOUT_2 = 1'b0; HRDATA_2 = $urandom;
      tick();
      HTRANS = 2'b00;
      @(negedge HCLK); model_eval(); checks++;
      if (HREADY !== 1'b0 || {HRESP, HRDATA} !== {exp_resp, exp_rdata}) begin
         errors++;
         $display("FAIL reset_stall: got rdy=%b resp=%b data=%h want 0 %b %h", HREADY, HRESP, HRDATA, exp_resp, exp_rdata);
      end
      #1 HRESETn = 1'b0; m_kind = 0;
      #1;
      checks++;
      if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_midstall: got rdy=%b resp=%b data=%h want 1 0 0", HREADY, HRESP, HRDATA);
      end
      @(posedge HCLK); #1;
      HRESETn = 1'b1; HREADYOUT_2 = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         @(negedge HCLK); checks++;
         if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_release%0d: got rdy=%b resp=%b data=%h want 1 0 0", k, HREADY, HRESP, HRDATA);
         end
      end
   endtask

   task automatic test_zero_wait();
      tick();
      MUX_SEL = 2'd2; ADDR_HIT = 1'b1; HTRANS = 2'b10; HRDATA_3 = 32'hCAFE0003; HREADYOUT_3 = 1'b1; HRESP_3 = 1'b0;
      tick();
      HTRANS = 2'b00;
      @(negedge HCLK); model_eval(); checks++;
      if (HRDATA !== 32'hCAFE0003 || HREADY !== 1'b1 || HRESP !== 1'b0 ||
          {HREADY, HRESP, HRDATA} !== {exp_ready, exp_resp, exp_rdata}) begin
         errors++;
         $display("FAIL zero_wait: got rdy=%b resp=%b data=%h want 1 0 cafe0003", HREADY, HRESP, HRDATA);
      end
   endtask

   task automatic test_wait_states();
      tick();
      MUX_SEL = 2'd0; ADDR_HIT = 1'b1; HTRANS = 2'b10; HREADYOUT_1 = 1'b1;
      tick();
      HREADYOUT_1 = 1'b0; MUX_SEL = 2'd3; HRDATA_4 = $urandom;
      for (int k = 0; k < 3; k++) begin
         HRDATA_1 = $urandom;
         @(negedge HCLK); model_eval(); checks++;
         if (HREADY !== 1'b0 || HRDATA !== HRDATA_1 || {HRESP, HRDATA} !== {exp_resp, exp_rdata}) begin
            errors++;
            $display("FAIL wait_state%0d: got rdy=%b data=%h want 0 %h", k, HREADY, HRDATA, HRDATA_1);
         end
         tick();
      end
      HREADYOUT_1 = 1'b1; HRDATA_1 = $urandom;
      @(negedge HCLK); checks++;
      if (HREADY !== 1'b1 || HRDATA !== HRDATA_1) begin
         errors++;
         $display("FAIL wait_release: got rdy=%b data=%h want 1 %h", HREADY, HRDATA, HRDATA_1);
      end
      tick();
      HTRANS = 2'b00;
      @(negedge HCLK); model_eval(); checks++;
      if (HRDATA !== HRDATA_4 || {HREADY, HRESP, HRDATA} !== {exp_ready, exp_resp, exp_rdata}) begin
         errors++;
         $display("FAIL wait_next_sel: got data=%h want %h", HRDATA, HRDATA_4);
      end
   endtask

   task automatic test_unmapped();
      tick();
      MUX_SEL = 2'($urandom); ADDR_HIT = 1'b0; HTRANS = 2'b10;
      tick();
      HTRANS = 2'b00;
      @(negedge HCLK); checks++;
      if (HREADY !== 1'b0 || HRESP !== 1'b1 || HRDATA !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_err1: got rdy=%b resp=%b data=%h want 0 1 0", HREADY, HRESP, HRDATA);
      end
      tick();
      MUX_SEL = 2'd0; ADDR_HIT = 1'b1; HTRANS = 2'b10; HRDATA_1 = $urandom; HRESP_1 = 1'b0; HREADYOUT_1 = 1'b1;
      @(negedge HCLK); checks++;
      if (HREADY !== 1'b1 || HRESP !== 1'b1 || HRDATA !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_err2: got rdy=%b resp=%b data=%h want 1 1 0", HREADY, HRESP, HRDATA);
      end
      tick();
      HTRANS = 2'b00;
      @(negedge HCLK); checks++;
      if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== HRDATA_1) begin
         errors++;
         $display("FAIL unmapped_then_okay: got rdy=%b resp=%b data=%h want 1 0 %h", HREADY, HRESP, HRDATA, HRDATA_1);
      end
   endtask

   task automatic test_unmapped_idle();
      for (int k = 0; k < 2; k++) begin
         tick();
         ADDR_HIT = 1'b0; HTRANS = (k == 0) ? 2'b00 : 2'b01;
         tick();
         @(negedge HCLK); checks++;
         if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_inactive%0d: got rdy=%b resp=%b data=%h want 1 0 0", k, HREADY, HRESP, HRDATA);
         end
      end
      HTRANS = 2'b00;
   endtask

   task automatic test_slave_error();
      tick();
      MUX_SEL = 2'd3; ADDR_HIT = 1'b1; HTRANS = 2'b10;
      tick();
      HTRANS = 2'b00; HREADYOUT_4 = 1'b0; HRESP_4 = 1'b1; HRDATA_4 = $urandom;
      @(negedge HCLK); checks++;
      if (HREADY !== 1'b0 || HRESP !== 1'b1) begin
         errors++;
         $display("FAIL slave_err1: got rdy=%b resp=%b want 0 1", HREADY, HRESP);
      end
      tick();
      HREADYOUT_4 = 1'b1;
      @(negedge HCLK); checks++;
      if (HREADY !== 1'b1 || HRESP !== 1'b1 || HRDATA !== HRDATA_4) begin
         errors++;
         $display("FAIL slave_err2: got rdy=%b resp=%b data=%h want 1 1 %h", HREADY, HRESP, HRDATA, HRDATA_4);
      end
      tick();
      HRESP_4 = 1'b0;
      @(negedge HCLK); checks++;
      if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
         errors++;
         $display("FAIL slave_err_after: got rdy=%b resp=%b data=%h want 1 0 0", HREADY, HRESP, HRDATA);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] seq_hit [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tick();
      for (int k = 0; k < 8; k++) begin
         MUX_SEL = 2'($urandom); ADDR_HIT = seq_hit[k][0]; HTRANS = 2'b11;
         HRDATA_1 = $urandom; HRDATA_2 = $urandom; HRDATA_3 = $urandom; HRDATA_4 = $urandom;
         for (int c = 0; c < 4; c++) begin
            @(negedge HCLK); model_eval(); checks++;
            if ({HREADY, HRESP, HRDATA} !== {exp_ready, exp_resp, exp_rdata}) begin
               errors++;
               $display("FAIL b2b%0d.%0d: got rdy=%b resp=%b data=%h want %b %b %h",
                        k, c, HREADY, HRESP, HRDATA, exp_ready, exp_resp, exp_rdata);
            end
            tick();
            if (exp_ready) break;
         end
      end
      HTRANS = 2'b00;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         MUX_SEL = 2'($urandom); ADDR_HIT = ($urandom_range(0, 3) != 0); HTRANS = 2'($urandom);
         HRDATA_1 = $urandom; HRDATA_2 = $urandom; HRDATA_3 = $urandom; HRDATA_4 = $urandom;
         HREADYOUT_1 = ($urandom_range(0, 3) != 0); HREADYOUT_2 = ($urandom_range(0, 3) != 0);
         HREADYOUT_3 = ($urandom_range(0, 3) != 0); HREADYOUT_4 = ($urandom_range(0, 3) != 0);
         HRESP_1 = 1'($urandom); HRESP_2 = 1'($urandom); HRESP_3 = 1'($urandom); HRESP_4 = 1'($urandom);
         @(negedge HCLK); model_eval(); checks++;
         if ({HREADY, HRESP, HRDATA} !== {exp_ready, exp_resp, exp_rdata}) begin
            errors++;
            $display("FAIL random%0d: got rdy=%b resp=%b data=%h want %b %b %h",
                     k, HREADY, HRESP, HRDATA, exp_ready, exp_resp, exp_rdata);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_unmapped();
      test_unmapped_idle();
      test_slave_error();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
